// File: rtl/fib_rf_seq.sv
// Register file with a built-in Fibonacci-style sequencer that writes a
// generated sequence into the file starting at a programmable base address.
module fib_rf_seq #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [AW-1:0]    len,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             wr_err,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD0 = 3'd1,
        LOAD1 = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    base_r, len_r, k_r;
    logic [WIDTH-1:0] seed0_r, seed1_r;

    logic             seq_we;
    logic [AW-1:0]    seq_addr;
    logic [WIDTH-1:0] seq_data;
    logic             wr_en, wr_ok;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH:0]   sum_full;

    // Handshake: start is a request with no ready; it is accepted only in the
    // cycle it is sampled high while busy=0, and is dropped otherwise.
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign wr_err    = busy && we;
    assign state_dbg = state;
    assign sum_full  = {1'b0, a} + {1'b0, b};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD0;
            LOAD0:   state_next = LOAD1;
            LOAD1:   state_next = (len_r != '0) ? RUN : DONE;
            RUN:     if (k_r == len_r - AW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        seq_we   = 1'b0;
        seq_addr = '0;
        seq_data = '0;
        case (state)
            LOAD0: begin
                seq_we   = 1'b1;
                seq_addr = base_r;
                seq_data = seed0_r;
            end
            LOAD1: begin
                seq_we   = 1'b1;
                seq_addr = base_r + AW'(1);
                seq_data = seed1_r;
            end
            RUN: begin
                seq_we   = 1'b1;
                seq_addr = base_r + k_r + AW'(2);
                seq_data = sum_full[WIDTH-1:0];
            end
            default: ;
        endcase
    end

    // The sequencer owns the write port while busy; external writes only land in IDLE.
    always_comb begin
        wr_en   = busy ? seq_we   : we;
        wr_addr = busy ? seq_addr : waddr;
        wr_data = busy ? seq_data : wdata;
        wr_ok   = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    end

    always_comb begin
        ra_data = mem[ra_addr];
        rb_data = mem[rb_addr];
        if (wr_ok && (wr_addr == ra_addr)) ra_data = wr_data;
        if (wr_ok && (wr_addr == rb_addr)) rb_data = wr_data;
        if ((ZERO_REG != 0) && (ra_addr == '0)) ra_data = '0;
        if ((ZERO_REG != 0) && (rb_addr == '0)) rb_data = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base_r  <= '0;
            len_r   <= '0;
            k_r     <= '0;
            seed0_r <= '0;
            seed1_r <= '0;
            ovf     <= 1'b0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r  <= base;
                        len_r   <= len;
                        seed0_r <= seed0;
                        seed1_r <= seed1;
                        ovf     <= 1'b0;
                    end
                end
                LOAD0: a <= seed0_r;
                LOAD1: begin
                    b   <= seed1_r;
                    k_r <= '0;
                end
                RUN: begin
                    // Operands come from a/b, so dropped writes to reg 0 cannot disturb the series.
                    a   <= b;
                    b   <= sum_full[WIDTH-1:0];
                    c   <= sum_full[WIDTH-1:0];
                    k_r <= k_r + AW'(1);
                    if (sum_full[WIDTH]) ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_rf_seq.sv
// Directed bench for fib_rf_seq: reset, sequence generation, bypass, overflow,
// address wrap, busy-write rejection and reset abort.
module tb_fib_rf_seq;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst, we, start;
  logic [AW-1:0]    waddr, ra_addr, rb_addr, base, len;
  logic [WIDTH-1:0] wdata, seed0, seed1;
  logic [WIDTH-1:0] ra_data, rb_data, a, b, c;
  logic             busy, done, ovf, wr_err;
  logic [2:0]       state_dbg;

  int vectors = 0;
  int miscompares = 0;

  fib_rf_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .start(start), .base(base), .len(len), .seed0(seed0), .seed1(seed1),
    .busy(busy), .done(done), .ovf(ovf), .wr_err(wr_err),
    .a(a), .b(b), .c(c), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] addr, output logic [WIDTH-1:0] da, output logic [WIDTH-1:0] db);
    ra_addr = addr;
    rb_addr = addr;
    #1;
    da = ra_data;
    db = rb_data;
  endtask

  // Launches a sequence and runs until one cycle past the first done pulse.
  task automatic run_seq(input logic [AW-1:0] bs, input logic [AW-1:0] ln,
                         input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                         output int done_at, output int pulses);
    done_at = 0;
    pulses  = 0;
    base  = bs;
    len   = ln;
    seed0 = s0;
    seed1 = s1;
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      start = 1'b0;
      if (done) begin
        pulses++;
        if (done_at == 0) done_at = n;
      end
      if (done_at != 0 && n >= done_at + 1) break;
    end
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] da, db;
    rst = 1'b1; we = 1'b0; start = 1'b0;
    waddr = '0; wdata = '0; base = '0; len = '0; seed0 = '0; seed1 = '0;
    ra_addr = '0; rb_addr = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy, done, ovf, wr_err} !== 4'b0000) begin
      $display("FAIL reset_flags got=%b exp=0000", {busy, done, ovf, wr_err});
      miscompares++;
    end
    vectors++;
    if (a !== '0 || b !== '0 || c !== '0) begin
      $display("FAIL reset_abc got a=%h b=%h c=%h exp 0", a, b, c);
      miscompares++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i), da, db);
      vectors++;
      if (da !== '0 || db !== '0) begin
        $display("FAIL reset_reg%0d got ra=%h rb=%h exp 0", i, da, db);
        miscompares++;
      end
    end
  endtask

  task automatic test_fib();
    logic [WIDTH-1:0] exp_v [7] = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};
    logic [WIDTH-1:0] da, db;
    int done_at, pulses;
    run_seq(5'd1, 5'd5, 32'd1, 32'd1, done_at, pulses);
    vectors++;
    if (done_at !== 8) begin
      $display("FAIL fib_latency got=%0d exp=8", done_at);
      miscompares++;
    end
    vectors++;
    if (pulses !== 1) begin
      $display("FAIL fib_done_pulses got=%0d exp=1", pulses);
      miscompares++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL fib_idle_after got busy=%b exp=0", busy);
      miscompares++;
    end
    vectors++;
    if (c !== 32'd13 || ovf !== 1'b0) begin
      $display("FAIL fib_c_ovf got c=%0d ovf=%b exp c=13 ovf=0", c, ovf);
      miscompares++;
    end
    for (int i = 0; i < 7; i++) begin
      rd(AW'(i + 1), da, db);
      vectors++;
      if (da !== exp_v[i] || db !== exp_v[i]) begin
        $display("FAIL fib_reg%0d got ra=%0d rb=%0d exp=%0d", i + 1, da, db, exp_v[i]);
        miscompares++;
      end
    end
    rd(5'd8, da, db);
    vectors++;
    if (da !== '0) begin
      $display("FAIL fib_reg8_untouched got=%h exp=0", da);
      miscompares++;
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF; ra_addr = 5'd3; rb_addr = 5'd2;
    #1;
    vectors++;
    if (ra_data !== 32'hDEADBEEF) begin
      $display("FAIL bypass_same_cycle got=%h exp=deadbeef", ra_data);
      miscompares++;
    end
    vectors++;
    if (rb_data !== 32'd1) begin
      $display("FAIL bypass_other_port got=%h exp=1", rb_data);
      miscompares++;
    end
    vectors++;
    if (wr_err !== 1'b0) begin
      $display("FAIL idle_write_no_err got=%b exp=0", wr_err);
      miscompares++;
    end
    tick();
    we = 1'b0; rb_addr = 5'd3;
    #1;
    vectors++;
    if (rb_data !== 32'hDEADBEEF) begin
      $display("FAIL write_committed got=%h exp=deadbeef", rb_data);
      miscompares++;
    end
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; ra_addr = 5'd0;
    #1;
    vectors++;
    if (ra_data !== '0) begin
      $display("FAIL zero_reg_bypass got=%h exp=0", ra_data);
      miscompares++;
    end
    tick();
    we = 1'b0;
    #1;
    vectors++;
    if (ra_data !== '0) begin
      $display("FAIL zero_reg_write got=%h exp=0", ra_data);
      miscompares++;
    end
  endtask

  task automatic test_ovf();
    logic [WIDTH-1:0] da, db;
    int done_at, pulses;
    run_seq(5'd4, 5'd2, 32'h80000000, 32'h80000000, done_at, pulses);
    vectors++;
    if (done_at !== 5 || pulses !== 1) begin
      $display("FAIL ovf_latency got at=%0d pulses=%0d exp at=5 pulses=1", done_at, pulses);
      miscompares++;
    end
    rd(5'd6, da, db);
    vectors++;
    if (da !== 32'h0) begin
      $display("FAIL ovf_reg6 got=%h exp=0", da);
      miscompares++;
    end
    rd(5'd7, da, db);
    vectors++;
    if (da !== 32'h80000000) begin
      $display("FAIL ovf_reg7 got=%h exp=80000000", da);
      miscompares++;
    end
    tick(); tick(); tick();
    vectors++;
    if (ovf !== 1'b1) begin
      $display("FAIL ovf_sticky got=%b exp=1", ovf);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] da, db;
    int done_at, pulses;
    base = 5'd30; len = 5'd3; seed0 = 32'd2; seed1 = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (ovf !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL wrap_start_clears_ovf got ovf=%b busy=%b exp ovf=0 busy=1", ovf, busy);
      miscompares++;
    end
    done_at = 0;
    pulses = 0;
    for (int n = 2; n <= 40; n++) begin
      tick();
      if (done) begin
        pulses++;
        if (done_at == 0) done_at = n;
      end
      if (done_at != 0 && n >= done_at + 1) break;
    end
    vectors++;
    if (done_at !== 6 || pulses !== 1) begin
      $display("FAIL wrap_latency got at=%0d pulses=%0d exp at=6 pulses=1", done_at, pulses);
      miscompares++;
    end
    rd(5'd30, da, db);
    vectors++;
    if (da !== 32'd2) begin $display("FAIL wrap_reg30 got=%0d exp=2", da); miscompares++; end
    rd(5'd31, da, db);
    vectors++;
    if (da !== 32'd3) begin $display("FAIL wrap_reg31 got=%0d exp=3", da); miscompares++; end
    rd(5'd0, da, db);
    vectors++;
    if (da !== 32'd0) begin $display("FAIL wrap_reg0 got=%0d exp=0", da); miscompares++; end
    rd(5'd1, da, db);
    vectors++;
    if (da !== 32'd8) begin $display("FAIL wrap_reg1 got=%0d exp=8", da); miscompares++; end
    rd(5'd2, da, db);
    vectors++;
    if (da !== 32'd13) begin $display("FAIL wrap_reg2 got=%0d exp=13", da); miscompares++; end
    vectors++;
    if (c !== 32'd13 || ovf !== 1'b0) begin
      $display("FAIL wrap_c_ovf got c=%0d ovf=%b exp c=13 ovf=0", c, ovf);
      miscompares++;
    end
  endtask

  task automatic test_busy_write();
    logic [WIDTH-1:0] da, db;
    int done_seen;
    base = 5'd8; len = 5'd5; seed0 = 32'd1; seed1 = 32'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (busy !== 1'b1 || state_dbg !== 3'd3) begin
      $display("FAIL busy_in_run got busy=%b state=%0d exp busy=1 state=3", busy, state_dbg);
      miscompares++;
    end
    we = 1'b1; waddr = 5'd20; wdata = 32'hAAAA5555;
    #1;
    vectors++;
    if (wr_err !== 1'b1) begin
      $display("FAIL wr_err_pulse got=%b exp=1", wr_err);
      miscompares++;
    end
    tick();
    we = 1'b0;
    #1;
    vectors++;
    if (wr_err !== 1'b0) begin
      $display("FAIL wr_err_clear got=%b exp=0", wr_err);
      miscompares++;
    end
    done_seen = 0;
    for (int n = 0; n < 20 && done_seen == 0; n++) begin
      tick();
      if (done) done_seen = 1;
    end
    vectors++;
    if (done_seen !== 1) begin
      $display("FAIL busy_write_done got=%0d exp=1", done_seen);
      miscompares++;
    end
    tick();
    rd(5'd20, da, db);
    vectors++;
    if (da !== '0) begin
      $display("FAIL busy_write_ignored got=%h exp=0", da);
      miscompares++;
    end
    rd(5'd14, da, db);
    vectors++;
    if (da !== 32'd21) begin
      $display("FAIL busy_seq_reg14 got=%0d exp=21", da);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] da, db;
    int done_at, pulses;
    base = 5'd10; len = 5'd0; seed0 = 32'd7; seed1 = 32'd9;
    start = 1'b1;
    tick();
    // Held start while busy must not relaunch with these new parameters.
    base = 5'd24; seed0 = 32'd55;
    done_at = 0;
    pulses = 0;
    for (int n = 2; n <= 40; n++) begin
      tick();
      if (n == 3) start = 1'b0;
      if (done) begin
        pulses++;
        if (done_at == 0) done_at = n;
      end
      if (done_at != 0 && n >= done_at + 1) break;
    end
    vectors++;
    if (done_at !== 3 || pulses !== 1) begin
      $display("FAIL len0_latency got at=%0d pulses=%0d exp at=3 pulses=1", done_at, pulses);
      miscompares++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      $display("FAIL busy_start_ignored got busy=%b exp=0", busy);
      miscompares++;
    end
    vectors++;
    if (a !== 32'd7 || b !== 32'd9) begin
      $display("FAIL len0_ab got a=%0d b=%0d exp a=7 b=9", a, b);
      miscompares++;
    end
    rd(5'd11, da, db);
    vectors++;
    if (da !== 32'd9) begin $display("FAIL len0_reg11 got=%0d exp=9", da); miscompares++; end
    rd(5'd24, da, db);
    vectors++;
    if (da !== 32'd0) begin $display("FAIL ignored_start_reg24 got=%0d exp=0", da); miscompares++; end
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH-1:0] da, db;
    int pulses;
    base = 5'd16; len = 5'd10; seed0 = 32'd3; seed1 = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      $display("FAIL abort_flags got busy=%b done=%b ovf=%b exp 0", busy, done, ovf);
      miscompares++;
    end
    vectors++;
    if (a !== '0 || b !== '0 || c !== '0) begin
      $display("FAIL abort_abc got a=%h b=%h c=%h exp 0", a, b, c);
      miscompares++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd(AW'(i), da, db);
      vectors++;
      if (da !== '0) begin
        $display("FAIL abort_reg%0d got=%h exp=0", i, da);
        miscompares++;
      end
    end
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (done) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      $display("FAIL abort_no_done got=%0d exp=0", pulses);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_fib();
    test_bypass();
    test_ovf();
    test_wrap();
    test_busy_write();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
